sopc4_out_pio: RTL and testbench
================================

Name: sopc4_out_pio

Overview:
- Avalon-MM slave output port. It is the write-side counterpart of the system's input PIOs.
- Drives a registered out_port from CPU writes. Supports whole-word write, atomic bit-set and bit-clear.
- Adds a hardware pulse generator: masked bits auto-clear after a programmed number of clk cycles.
- Sits on the SOPC system interconnect next to the input PIOs; out_port goes to board pins or other fabric logic.

Parameters:
- DATA_WIDTH, 32, width of out_port and data registers (1..32).
- RESET_VALUE, 0, value loaded into out_port on reset.
- CNT_WIDTH, 16, width of PULSE_LEN and the pulse counter (1..31).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- chipselect  in  1  slave select; read/write ignored when 0.
- address  in  3  word register index.
- write  in  1  write strobe, single-cycle, no wait states.
- writedata  in  32  write data; bits above DATA_WIDTH ignored.
- read  in  1  read strobe.
- readdata  out  32  registered read data.
- out_port  out  DATA_WIDTH  output port value.

Behaviour:
- Reset: reset_n, asynchronous, active-low; clock clk. While reset_n=0:
  - out_port=RESET_VALUE, readdata=0.
  - PULSE_MASK=0, PULSE_LEN=0, counter=0, busy=0.
- Register map (word addresses):
  - 0 DATA RW: write sets out_port=writedata; read returns out_port.
  - 1 SET W: out_port |= writedata; reads 0.
  - 2 CLR W: out_port &= ~writedata; reads 0.
  - 3 PULSE_MASK RW: bits subject to auto-clear.
  - 4 PULSE_LEN RW: pulse length in cycles, CNT_WIDTH bits, zero-extended on read.
  - 5 STATUS R: bit0=busy, bits[CNT_WIDTH:1]=remaining count, others 0.
  - 6,7 reserved: writes ignored, reads 0.
- Writes take effect at the clk edge where chipselect&write=1. Zero wait states.
- Reads:
  - readdata is registered: updated on the edge where chipselect&read=1, valid the following cycle (1-cycle latency).
  - readdata holds its value otherwise.
  - A read and a write in the same cycle to the same register return the pre-write value.
- Unused out_port bits do not exist; upper writedata/readdata bits beyond DATA_WIDTH are read as 0.
- Pulse engine, trigger:
  - Arms on a write to DATA or SET when the resulting out_port value & PULSE_MASK ≠ 0 and PULSE_LEN ≠ 0.
  - At that same edge: counter=PULSE_LEN, busy=1.
  - Masked bits therefore stay high for exactly PULSE_LEN cycles.
- Pulse engine, count and expiry:
  - While busy, and no new trigger is present, counter decrements by 1 each edge.
  - At the edge where counter==1: out_port &= ~PULSE_MASK (mask value at that edge), counter=0, busy=0.
- Retrigger: a trigger while busy reloads counter=PULSE_LEN (restart, no accumulation).
- Simultaneous events:
  - A trigger on the expiry edge wins: new out_port value applied, counter reloaded, no clear.
  - A CLR write on the expiry edge: both clears applied (OR of clear masks).
  - A non-triggering write to DATA on the expiry edge: written value applied, then PULSE_MASK bits cleared.
- Writes to PULSE_LEN or PULSE_MASK while busy:
  - Do not affect the running counter.
  - The new mask is used at expiry.
- PULSE_LEN=0 disables the engine: no trigger, plain latch behaviour.
- Counter never wraps; it stops at 0.
- Reset asserted mid-pulse aborts immediately to reset values.

Test Plan:
- Reset and defaults: RESET_VALUE=0x0000_00A5; release reset, read DATA → readdata=0x0000_00A5 one cycle after the read strobe; STATUS reads 0.
- Set/clear: write DATA=0xF0F0_0000, SET=0x0000_000F, CLR=0xF000_0000 → out_port=0x00F0_000F after the third write edge; SET/CLR read back 0.
- Basic pulse: PULSE_MASK=0x1, PULSE_LEN=5, write SET=0x1 → out_port[0] high for exactly 5 cycles, then 0. STATUS shows busy=1 and counts 5,4,3,2,1, then busy=0.
- Retrigger and expiry collision: with PULSE_LEN=4, issue SET=0x1, then SET=0x1 again on the expiry edge → bit stays high with no glitch, and stays high 4 cycles after the second write.
- Non-pulse bits and disable:
  - PULSE_MASK=0x1, write DATA=0x3 with PULSE_LEN=3 → after 3 cycles out_port=0x2.
  - Then PULSE_LEN=0, write DATA=0x1 → bit stays high indefinitely.
- Reset mid-pulse and reserved addresses:
  - Assert reset_n=0 during a pulse with count=2 → out_port=RESET_VALUE and busy=0 asynchronously.
  - Write to address 6 → no register changes; a read of address 6 returns 0.

Source files
------------

// File: rtl/sopc4_out_pio.sv
// Avalon-MM output PIO: registered out_port with word write, atomic set/clear,
// and a pulse engine that auto-clears masked bits after PULSE_LEN cycles.
module sopc4_out_pio #(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter int                    CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  chipselect,
  input  logic [2:0]            address,
  input  logic                  write,
  input  logic [31:0]           writedata,
  input  logic                  read,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port
);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_SET    = 3'd1;
  localparam logic [2:0] ADDR_CLR    = 3'd2;
  localparam logic [2:0] ADDR_MASK   = 3'd3;
  localparam logic [2:0] ADDR_LEN    = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;

  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [CNT_WIDTH-1:0]  len_q, len_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] port_wr, port_d;
  logic [DATA_WIDTH-1:0] wdata;
  logic [31:0]           rd_mux;
  logic                  wr_en, rd_en, trigger, expire;

  assign wr_en = chipselect & write;
  assign rd_en = chipselect & read;
  assign wdata = writedata[DATA_WIDTH-1:0];

  always_comb begin
    port_wr = out_port;
    mask_d  = mask_q;
    len_d   = len_q;
    if (wr_en) begin
      case (address)
        ADDR_DATA: port_wr = wdata;
        ADDR_SET:  port_wr = out_port | wdata;
        ADDR_CLR:  port_wr = out_port & ~wdata;
        ADDR_MASK: mask_d  = wdata;
        ADDR_LEN:  len_d   = writedata[CNT_WIDTH-1:0];
        default:   ;
      endcase
    end
  end

  // A trigger is judged on the post-write port value, so SET of an already
  // high masked bit still retriggers.
  assign trigger = wr_en && (address == ADDR_DATA || address == ADDR_SET) &&
                   ((port_wr & mask_q) != '0) && (len_q != '0);

  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    expire = 1'b0;
    if (trigger) begin
      cnt_d  = len_q;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (cnt_q <= CNT_WIDTH'(1)) begin
        cnt_d  = '0;
        busy_d = 1'b0;
        expire = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_WIDTH'(1);
      end
    end
  end

  // Expiry clear is layered on top of whatever the bus wrote this edge.
  assign port_d = expire ? (port_wr & ~mask_q) : port_wr;

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:   rd_mux = 32'(out_port);
      ADDR_MASK:   rd_mux = 32'(mask_q);
      ADDR_LEN:    rd_mux = 32'(len_q);
      ADDR_STATUS: rd_mux = 32'({cnt_q, busy_q});
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_port <= RESET_VALUE;
      readdata <= '0;
      mask_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      out_port <= port_d;
      mask_q   <= mask_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      if (rd_en) readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_sopc4_out_pio.sv
// Directed bench for sopc4_out_pio: bus driver tasks push expected read data
// and per-cycle out_port values; a negedge monitor pops and compares.
module tb_sopc4_out_pio;

  localparam logic [31:0] RST_VAL = 32'h0000_00A5;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        chipselect;
  logic [2:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;
  logic [31:0] out_port;

  logic [31:0] exp_q[$];
  logic [31:0] port_q[$];
  logic        rd_pend = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  sopc4_out_pio #(
    .DATA_WIDTH (32),
    .RESET_VALUE(RST_VAL),
    .CNT_WIDTH  (16)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .chipselect(chipselect),
    .address   (address),
    .write     (write),
    .writedata (writedata),
    .read      (read),
    .readdata  (readdata),
    .out_port  (out_port)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: read data appears the cycle after the read edge.
  always @(posedge clk) rd_pend <= chipselect & read;

  always @(negedge clk) begin
    if (rd_pend) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL readdata: unexpected response %h, nothing expected", readdata);
      end else begin
        check("readdata", readdata, exp_q.pop_front());
      end
    end
    if (port_q.size() != 0) check("out_port", out_port, port_q.pop_front());
  end

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [31:0] exp);
    chipselect = 1'b1; read = 1'b1; address = a;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic bus_rw(input logic [2:0] a, input logic [31:0] d, input logic [31:0] exp);
    chipselect = 1'b1; read = 1'b1; write = 1'b1; address = a; writedata = d;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
  endtask

  // Expect out_port value for the current cycle, then advance one clock.
  task automatic tick(input logic [31:0] exp);
    port_q.push_back(exp);
    @(posedge clk); #1;
  endtask

  initial begin
    reset_n = 1'b0; chipselect = 1'b0; address = '0; write = 1'b0;
    writedata = '0; read = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("readdata_in_reset", readdata, 32'h0);
    tick(RST_VAL);
    reset_n = 1'b1;

    // Reset defaults
    bus_read(3'd0, RST_VAL);
    bus_read(3'd5, 32'h0);
    bus_read(3'd3, 32'h0);
    bus_read(3'd4, 32'h0);

    // Whole-word write, set, clear
    bus_write(3'd0, 32'hF0F0_0000);
    bus_write(3'd1, 32'h0000_000F);
    bus_write(3'd2, 32'hF000_0000);
    tick(32'h00F0_000F);
    bus_read(3'd1, 32'h0);
    bus_read(3'd2, 32'h0);
    bus_read(3'd0, 32'h00F0_000F);

    // Basic 5-cycle pulse with STATUS countdown
    bus_write(3'd0, 32'h0);
    bus_write(3'd3, 32'h1);
    bus_write(3'd4, 32'h5);
    bus_read(3'd3, 32'h1);
    bus_read(3'd4, 32'h5);
    bus_write(3'd1, 32'h1);
    port_q.push_back(32'h1); bus_read(3'd5, {15'd0, 16'd5, 1'b1});
    port_q.push_back(32'h1); bus_read(3'd5, {15'd0, 16'd4, 1'b1});
    port_q.push_back(32'h1); bus_read(3'd5, {15'd0, 16'd3, 1'b1});
    port_q.push_back(32'h1); bus_read(3'd5, {15'd0, 16'd2, 1'b1});
    port_q.push_back(32'h1); bus_read(3'd5, {15'd0, 16'd1, 1'b1});
    port_q.push_back(32'h0); bus_read(3'd5, 32'h0);

    // Retrigger exactly on the expiry edge
    bus_write(3'd4, 32'h4);
    bus_write(3'd1, 32'h1);
    tick(32'h1); tick(32'h1); tick(32'h1);
    bus_write(3'd1, 32'h1);
    port_q.push_back(32'h1); bus_read(3'd5, {15'd0, 16'd4, 1'b1});
    tick(32'h1); tick(32'h1); tick(32'h1);
    tick(32'h0);

    // Unmasked bits survive expiry
    bus_write(3'd4, 32'h3);
    bus_write(3'd0, 32'h3);
    tick(32'h3); tick(32'h3); tick(32'h3);
    tick(32'h2);

    // CLR landing on the expiry edge: both clears apply
    bus_write(3'd4, 32'h2);
    bus_write(3'd0, 32'h3);
    tick(32'h3);
    bus_write(3'd2, 32'h2);
    tick(32'h0);

    // PULSE_LEN=0 disables the engine
    bus_write(3'd4, 32'h0);
    bus_write(3'd0, 32'h1);
    for (int i = 0; i < 6; i++) tick(32'h1);
    bus_read(3'd5, 32'h0);

    // Asynchronous reset mid-pulse with count=2
    bus_write(3'd4, 32'h4);
    bus_read(3'd3, 32'h1);
    bus_write(3'd1, 32'h1);
    tick(32'h1); tick(32'h1);
    reset_n = 1'b0;
    #1;
    check("out_port_async_reset", out_port, RST_VAL);
    check("readdata_async_reset", readdata, 32'h0);
    tick(RST_VAL);
    tick(RST_VAL);
    reset_n = 1'b1;
    bus_read(3'd5, 32'h0);
    bus_read(3'd3, 32'h0);
    bus_read(3'd4, 32'h0);

    // Reserved addresses and deselected writes
    bus_write(3'd6, 32'hFFFF_FFFF);
    bus_write(3'd7, 32'hFFFF_FFFF);
    tick(RST_VAL);
    bus_read(3'd6, 32'h0);
    bus_read(3'd7, 32'h0);
    bus_read(3'd0, RST_VAL);
    bus_read(3'd3, 32'h0);
    bus_read(3'd4, 32'h0);
    write = 1'b1; address = 3'd0; writedata = 32'h1234_5678;
    @(posedge clk); #1;
    write = 1'b0;
    tick(RST_VAL);

    // Same-cycle read and write returns the pre-write value
    bus_rw(3'd0, 32'h0000_0055, RST_VAL);
    bus_read(3'd0, 32'h0000_0055);

    repeat (3) @(posedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'h0);
    check("port_q_drained", 32'(port_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
